// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, operation and state encodings for the divider
package div_unit_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: operand magnitudes for signed ops and RV32M sign restoration of the result
module div_sign_fix
   import div_unit_pkg::*;
(
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] rem_i,
   output logic [XLEN-1:0] a_mag_o,
   output logic [XLEN-1:0] b_mag_o,
   output logic [XLEN-1:0] res_o
);
   logic a_neg, b_neg;
   // op bit 0 clear marks the signed forms (DIV, REM)
   assign a_neg   = ~op_i[0] & a_i[XLEN-1];
   assign b_neg   = ~op_i[0] & b_i[XLEN-1];
   assign a_mag_o = a_neg ? -a_i : a_i;
   assign b_mag_o = b_neg ? -b_i : b_i;
   assign res_o   = op_i[1] ? (a_neg ? -rem_i : rem_i) : ((a_neg ^ b_neg) ? -quo_i : quo_i);
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU) with single-cycle special cases
module div_unit #(
   parameter int XLEN = div_unit_pkg::XLEN
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [1:0]      OP,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);
   import div_unit_pkg::*;
   state_e state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [XLEN:0] rem_q, rem_d, sh, diff, rem_n;
   logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d, a_q, a_d, b_q, b_d, res_q, res_d, quo_n;
   logic [XLEN-1:0] sf_a, sf_b, a_mag, b_mag, fix_res;
   logic [1:0] op_q, op_d, sf_op;
   logic idle, div0, ovf, rem_unused;
   assign idle = state_q == S_IDLE;
   assign sf_a = idle ? DATA1 : a_q;
   assign sf_b = idle ? DATA2 : b_q;
   assign sf_op = idle ? OP : op_q;
   assign div0 = DATA2 == '0;
   assign ovf = (OP == OP_DIV || OP == OP_REM) && DATA1 == {1'b1, {(XLEN-1){1'b0}}} && DATA2 == '1;
   // one restoring step: shift in the next dividend bit, keep the difference unless it borrows
   assign sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
   assign diff = sh - {1'b0, dvs_q};
   assign rem_n = diff[XLEN] ? sh : diff;
   assign quo_n = {quo_q[XLEN-2:0], ~diff[XLEN]};
   assign rem_unused = rem_q[XLEN];
   div_sign_fix u_sign_fix (
      .op_i   (sf_op),
      .a_i    (sf_a),
      .b_i    (sf_b),
      .quo_i  (quo_n),
      .rem_i  (rem_n[XLEN-1:0]),
      .a_mag_o(a_mag),
      .b_mag_o(b_mag),
      .res_o  (fix_res)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      res_d = res_q;
      case (state_q)
         S_IDLE: if (START) begin
            a_d = DATA1;
            b_d = DATA2;
            op_d = OP;
            dvs_d = b_mag;
            quo_d = a_mag;
            rem_d = '0;
            cnt_d = '0;
            state_d = (div0 || ovf) ? S_FIN : S_CALC;
            res_d = div0 ? (OP[1] ? DATA1 : '1) : ovf ? (OP[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}}) : res_q;
         end
         S_CALC: begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q + 6'd1;
            state_d = (cnt_q == 6'd31) ? S_FIN : S_CALC;
            res_d = (cnt_q == 6'd31) ? fix_res : res_q;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         res_q <= res_d;
      end
   end
   assign BUSY = ~idle;
   assign DONE = state_q == S_FIN;
   assign RESULT = res_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed corner cases plus randomized back-to-back requests against an arithmetic model
module tb_div_unit;
   logic clk, rst, start, busy, done;
   logic [1:0] op;
   logic [31:0] data1, data2, result;
   int errs = 0;
   int checks = 0;

   div_unit dut (
      .CLK   (clk),
      .RESET (rst),
      .START (start),
      .OP    (op),
      .DATA1 (data1),
      .DATA2 (data2),
      .BUSY  (busy),
      .DONE  (done),
      .RESULT(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic bypass(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
         return o[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return o[1] ? a % b : a / b;
   endfunction

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int n, busy_n;
      start = 1'b1;
      op = o;
      data1 = a;
      data2 = b;
      tick();
      start = 1'b0;
      op = ~o;
      data1 = $urandom;
      data2 = $urandom;
      n = 1;
      busy_n = int'(busy);
      while (!done && n < 100) begin
         tick();
         n++;
         busy_n += int'(busy);
      end
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " result"}, result, exp);
      check({tag, " busy cycles"}, 32'(busy_n), 32'(lat));
      tick();
      check({tag, " back to idle"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      int dones, ops, k, lat, cyc, sel;
      logic act, cool;
      logic [1:0] ro;
      logic [31:0] ra, rb, got, exp_res, last_res;
      rst = 1'b1;
      start = 1'b1;
      op = 2'b00;
      data1 = 32'd1;
      data2 = 32'd1;
      tick();
      tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick();
      check("idle without start", 32'(busy), 32'd0);

      run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
      run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
      run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      run_op("div 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
      run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

      start = 1'b1;
      op = 2'b01;
      data1 = 32'd9;
      data2 = 32'd3;
      tick();
      dones = 0;
      got = 32'd0;
      for (int c = 1; c <= 60; c++) begin
         if (done) begin
            dones++;
            got = result;
         end
         start = (c == 10);
         data1 = 32'd8;
         data2 = 32'd2;
         tick();
      end
      start = 1'b0;
      check("start while busy done count", 32'(dones), 32'd1);
      check("start while busy result", got, 32'd3);

      start = 1'b1;
      op = 2'b01;
      data1 = 32'd1000;
      data2 = 32'd3;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", result, 32'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         dones += int'(done);
      end
      check("abort no done", 32'(dones), 32'd0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_res = 32'd0;
      act = 1'b0;
      cool = 1'b0;
      k = 0;
      lat = 0;
      exp_res = 32'd0;
      ops = 0;
      cyc = 0;
      while (ops < 1000 && cyc < 60000) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         sel = $urandom_range(0, 9);
         rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
         if (sel == 1 && $urandom_range(0, 1) == 1) ra = 32'h8000_0000;
         start = 1'b1;
         op = ro;
         data1 = ra;
         data2 = rb;
         tick();
         cyc++;
         if (cool) cool = 1'b0;
         else if (!act) begin
            act = 1'b1;
            k = 1;
            exp_res = model(ro, ra, rb);
            lat = bypass(ro, ra, rb) ? 1 : 33;
         end else k++;
         check("rand busy", 32'(busy), 32'(act));
         check("rand done", 32'(done), 32'(act && k == lat));
         if (act && k == lat) begin
            check("rand result", result, exp_res);
            last_res = exp_res;
            act = 1'b0;
            cool = 1'b1;
            ops++;
         end else check("rand result hold", result, last_res);
      end
      start = 1'b0;
      check("rand ops completed", 32'(ops), 32'd1000);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
